// File: rtl/axi_mem_loader.sv
// AXI4 write-only initiator: buffers a length-tagged byte stream in a FIFO and writes it out as INCR bursts,
// one burst outstanding. Optional macro AXI_LOADER_ABORT_ON_ERR_EN ends the job after the first errored burst.
module axi_mem_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_W_WIDTH = 5,
  parameter int WR_ID      = 0,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ID_W_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    m_axi_arvalid,
  output logic                    m_axi_rready
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BLEN_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_AW, S_W, S_B, S_FIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  rem;
  logic [LEN_WIDTH-1:0]  need;
  logic [BLEN_W-1:0]     blen;
  logic [BLEN_W-1:0]     beat_cnt;
  logic [12:0]           bnd;
  logic                  start_acc;
  logic                  job_active;
  logic                  last_beat;
  logic                  push, pop, full;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  // Burst length: limited by MAX_BURST, remaining bytes and distance to the next 4 KB page.
  assign bnd = 13'h1000 - {1'b0, addr[11:0]};

  always_comb begin
    blen = BLEN_W'(MAX_BURST);
    if (32'(rem) < 32'(blen)) blen = BLEN_W'(rem);
    if (32'(bnd) < 32'(blen)) blen = BLEN_W'(bnd);
  end

  assign job_active = (state == S_WAIT) || (state == S_AW) || (state == S_W) || (state == S_B);
  assign last_beat  = (beat_cnt == blen - BLEN_W'(1));
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign pop        = m_axi_wvalid && m_axi_wready;

  assign s_ready       = job_active && !full && (need != '0);
  assign busy          = job_active;
  assign done          = (state == S_FIN);
  assign m_axi_awid    = ID_W_WIDTH'(WR_ID);
  assign m_axi_awaddr  = addr;
  assign m_axi_awlen   = 8'(blen - BLEN_W'(1));
  assign m_axi_awsize  = 3'($clog2(DATA_WIDTH/8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state == S_AW);
  assign m_axi_wdata   = mem[rd_ptr];
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state == S_W) && (count != '0);
  assign m_axi_wlast   = (state == S_W) && last_beat;
  assign m_axi_bready  = (state == S_B);
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (len == '0) ? S_FIN : S_WAIT;
        end
      end
      S_WAIT: if (32'(count) >= 32'(blen)) state_nxt = S_AW;
      S_AW:   if (m_axi_awready) state_nxt = S_W;
      S_W:    if (pop && last_beat) state_nxt = S_B;
      S_B: begin
        if (m_axi_bvalid) begin
          if (rem == LEN_WIDTH'(blen)) state_nxt = S_FIN;
`ifdef AXI_LOADER_ABORT_ON_ERR_EN
          else if (m_axi_bresp != 2'b00) state_nxt = S_FIN;
`endif
          else state_nxt = S_WAIT;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      rem      <= '0;
      need     <= '0;
      err      <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        addr <= base_addr;
        rem  <= len;
        need <= len;
        err  <= 1'b0;
      end else begin
        if (push) need <= need - LEN_WIDTH'(1);
        if (state == S_B && m_axi_bvalid) begin
          addr <= addr + ADDR_WIDTH'(blen);
          rem  <= rem - LEN_WIDTH'(blen);
          if (m_axi_bresp != 2'b00) err <= 1'b1;
        end
      end
      if (state == S_AW)  beat_cnt <= '0;
      else if (pop)       beat_cnt <= beat_cnt + BLEN_W'(1);
    end
  end

  // A new job flushes any bytes left behind by an aborted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_acc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_axi_mem_loader.sv
// Directed bench for axi_mem_loader: an AXI write responder with a byte RAM, protocol monitors and
// hand-computed expectations for burst splitting, backpressure, error response and mid-burst reset.
module tb_axi_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] len = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, busy, done, err;
  logic [4:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [7:0]  wdata;
  logic [0:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready, arvalid, rready;

  axi_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .busy(busy), .done(done), .err(err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

`ifdef AXI_LOADER_ABORT_ON_ERR_EN
  localparam int ERR_BURSTS = 2;
`else
  localparam int ERR_BURSTS = 3;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] ram [65536];
  logic [7:0] img [256];
  int aw_addr_q[$];
  int aw_len_q[$];

  int max_delay = 0;
  int err_burst = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0;
  int b_pending = 0, w_left = 0, w_addr = 0, outstanding = 0, b_count = 0;
  int stall_viol = 0, proto_viol = 0, wlast_viol = 0, w_hs_count = 0, done_cnt = 0;
  logic        aw_stalled = 1'b0, w_stalled = 1'b0;
  logic [15:0] aw_hold_addr;
  logic [7:0]  aw_hold_len, w_hold_data;
  logic        w_hold_last;

  // Responder: decides ready/valid at the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      b_pending = 0; w_left = 0; outstanding = 0;
      aw_stalled = 1'b0; w_stalled = 1'b0;
    end else begin
      if (w_stalled && !(wvalid && wdata == w_hold_data && wlast == w_hold_last)) stall_viol++;
      wready = 1'b0;
      if (wvalid) begin
        if (w_left == 0) proto_viol++;
        else if (w_wait > 0) w_wait--;
        else wready = 1'b1;
      end
      w_stalled = wvalid && !wready && (w_left != 0);
      w_hold_data = wdata; w_hold_last = wlast;
      if (wvalid && wready) begin
        ram[w_addr] = wdata;
        w_addr = (w_addr + 1) & 16'hffff;
        if (wlast != (w_left == 1)) wlast_viol++;
        w_left--;
        w_hs_count++;
        w_wait = $urandom_range(max_delay, 0);
        if (w_left == 0) begin
          b_pending = 1;
          b_wait = $urandom_range(max_delay, 0);
        end
      end

      if (aw_stalled && !(awvalid && awaddr == aw_hold_addr && awlen == aw_hold_len)) stall_viol++;
      awready = 1'b0;
      if (awvalid) begin
        if (aw_wait > 0) aw_wait--;
        else awready = 1'b1;
      end
      aw_stalled = awvalid && !awready;
      aw_hold_addr = awaddr; aw_hold_len = awlen;
      if (awvalid && awready) begin
        if (outstanding != 0) proto_viol++;
        outstanding++;
        aw_addr_q.push_back(int'(awaddr));
        aw_len_q.push_back(int'(awlen));
        w_addr = int'(awaddr);
        w_left = int'(awlen) + 1;
        aw_wait = $urandom_range(max_delay, 0);
      end

      bvalid = 1'b0; bresp = 2'b00;
      if (b_pending != 0) begin
        if (b_wait > 0) b_wait--;
        else if (bready) begin
          bvalid = 1'b1;
          b_count++;
          bresp = (b_count == err_burst) ? 2'b10 : 2'b00;
          b_pending = 0;
          outstanding--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] b, input logic [15:0] l);
    aw_addr_q.delete();
    aw_len_q.delete();
    b_count = 0; stall_viol = 0; proto_viol = 0; wlast_viol = 0; w_hs_count = 0;
    @(negedge clk);
    base_addr = b; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams img[0..l-1] while the job is busy; sparse>0 leaves random gaps in s_valid.
  task automatic run_job(input string tag, input logic [15:0] b, input int l, input int sparse,
                         input int limit, output int dones);
    int idx, cycles, d0;
    d0 = done_cnt;
    start_job(b, 16'(l));
    idx = 0; cycles = 0;
    while (busy && cycles < limit) begin
      if (idx < l && (sparse == 0 || $urandom_range(sparse, 0) == 0)) begin
        s_valid = 1'b1;
        s_data  = img[idx];
        if (s_ready) idx++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    s_valid = 1'b0;
    if (cycles >= limit) check({tag, "_timeout"}, 32'(cycles), 32'(limit - 1));
    repeat (3) @(negedge clk);
    dones = done_cnt - d0;
  endtask

  task automatic ram_diff(input int b, input int l, output int bad);
    bad = 0;
    for (int i = 0; i < l; i++) if (ram[(b + i) & 16'hffff] !== img[i]) bad++;
  endtask

  initial begin
    int dones, bad;
    for (int i = 0; i < 65536; i++) ram[i] = 8'hee;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, done, err, s_ready, awvalid, wvalid, bready, arvalid, rready}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("fixed_fields", 32'({awsize, awburst, wstrb, awid}), 32'({3'd0, 2'd1, 1'b1, 5'd0}));

    // Basic load: 9 little-endian words, fifth word is 2.
    for (int i = 0; i < 36; i++) img[i] = (i % 4 != 0) ? 8'h00 : ((i / 4 == 4) ? 8'h02 : 8'h01);
    run_job("basic", 16'ha000, 36, 0, 2000, dones);
    check("basic_aw_count", 32'(aw_addr_q.size()), 32'd3);
    check("basic_aw0", 32'(aw_addr_q[0]), 32'ha000);
    check("basic_aw1", 32'(aw_addr_q[1]), 32'ha010);
    check("basic_aw2", 32'(aw_addr_q[2]), 32'ha020);
    check("basic_len0", 32'(aw_len_q[0]), 32'd15);
    check("basic_len1", 32'(aw_len_q[1]), 32'd15);
    check("basic_len2", 32'(aw_len_q[2]), 32'd3);
    check("basic_word4", 32'(ram[16'ha010]), 32'h02);
    check("basic_word5", 32'(ram[16'ha014]), 32'h01);
    check("basic_no_overrun", 32'(ram[16'ha024]), 32'hee);
    ram_diff(16'ha000, 36, bad);
    check("basic_data", 32'(bad), 32'd0);
    check("basic_done_pulses", 32'(dones), 32'd1);
    check("basic_err", 32'(err), 32'd0);
    check("basic_proto", 32'(proto_viol + wlast_viol), 32'd0);

    // 4 KB boundary split.
    for (int i = 0; i < 10; i++) img[i] = 8'(8'h30 + i);
    run_job("split", 16'h0ffa, 10, 0, 2000, dones);
    check("split_aw_count", 32'(aw_addr_q.size()), 32'd2);
    check("split_aw0", 32'(aw_addr_q[0]), 32'h0ffa);
    check("split_len0", 32'(aw_len_q[0]), 32'd5);
    check("split_aw1", 32'(aw_addr_q[1]), 32'h1000);
    check("split_len1", 32'(aw_len_q[1]), 32'd3);
    check("split_wlast", 32'(wlast_viol), 32'd0);
    check("split_last_low", 32'(ram[16'h0fff]), 32'h35);
    check("split_first_high", 32'(ram[16'h1000]), 32'h36);
    check("split_end", 32'(ram[16'h1003]), 32'h39);

    // Zero length: done on the cycle after the start is accepted, no AW.
    start_job(16'h5000, 16'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("zero_done_once", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_no_aw", 32'(aw_addr_q.size()), 32'd0);

    // Backpressure on every channel plus a sparse input stream.
    max_delay = 7;
    for (int i = 0; i < 40; i++) img[i] = 8'($urandom_range(255, 0));
    run_job("bp", 16'h2005, 40, 3, 5000, dones);
    max_delay = 0;
    check("bp_aw_count", 32'(aw_addr_q.size()), 32'd3);
    check("bp_aw1", 32'(aw_addr_q[1]), 32'h2015);
    check("bp_aw2", 32'(aw_addr_q[2]), 32'h2025);
    check("bp_len2", 32'(aw_len_q[2]), 32'd7);
    ram_diff(16'h2005, 40, bad);
    check("bp_data", 32'(bad), 32'd0);
    check("bp_stable", 32'(stall_viol), 32'd0);
    check("bp_one_outstanding", 32'(proto_viol), 32'd0);
    check("bp_wlast", 32'(wlast_viol), 32'd0);
    check("bp_done", 32'(dones), 32'd1);

    // SLVERR on the second of three bursts.
    for (int i = 0; i < 36; i++) img[i] = 8'(8'h80 + i);
    err_burst = 2;
    run_job("error", 16'h3000, 36, 0, 2000, dones);
    err_burst = 0;
    check("error_err", 32'(err), 32'd1);
    check("error_bursts", 32'(aw_addr_q.size()), 32'(ERR_BURSTS));
    check("error_done", 32'(dones), 32'd1);
    check("error_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) img[i] = 8'(8'hc0 + i);
    run_job("clear", 16'h3100, 4, 0, 2000, dones);
    check("clear_err", 32'(err), 32'd0);
    ram_diff(16'h3100, 4, bad);
    check("clear_data", 32'(bad), 32'd0);

    // Reset asserted between clock edges on the fifth beat of a 16-beat burst.
    for (int i = 0; i < 16; i++) img[i] = 8'(8'h50 + i);
    start_job(16'h4000, 16'd16);
    begin
      int idx, cycles;
      idx = 0; cycles = 0;
      while (busy && w_hs_count < 5 && cycles < 500) begin
        s_valid = (idx < 16);
        s_data  = img[idx];
        if (s_valid && s_ready) idx++;
        @(negedge clk);
        cycles++;
      end
      s_valid = 1'b0;
    end
    check("rst_reached_beat5", 32'(w_hs_count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valids_drop", 32'({awvalid, wvalid, bready, s_ready, busy, done}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) img[i] = 8'(8'ha0 + i);
    run_job("restart", 16'h4000, 16, 0, 2000, dones);
    check("restart_aw_count", 32'(aw_addr_q.size()), 32'd1);
    check("restart_len", 32'(aw_len_q[0]), 32'd15);
    ram_diff(16'h4000, 16, bad);
    check("restart_data", 32'(bad), 32'd0);
    check("restart_done", 32'(dones), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
